// File: rtl/pipeline_wb_regfile.sv
// Write-back stage and register file of the 8-bit pipelined core.
// Selects the write-back data, commits it to the register file, serves two decode read ports and counts commits.
module pipeline_wb_regfile #(
  parameter int DW     = 8,
  parameter int AW     = 2,
  parameter int CNT_W  = 16,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    DM,
  input  logic [DW-1:0]    ALU_ea,
  input  logic [AW-1:0]    ra,
  input  logic             wb_wb_sel,
  input  logic             wb_reg_en,
  input  logic [AW-1:0]    rs_a,
  input  logic [AW-1:0]    rs_b,
  output logic [DW-1:0]    rd_a,
  output logic [DW-1:0]    rd_b,
  output logic [DW-1:0]    wb_data,
  output logic             wb_fwd_en,
  output logic [CNT_W-1:0] wr_cnt
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0]    regs_q [NREG];
  logic [DW-1:0]    regs_d [NREG];
  logic [CNT_W-1:0] wr_cnt_q;
  logic [CNT_W-1:0] wr_cnt_d;

  always_comb begin
    wb_data   = wb_wb_sel ? DM : ALU_ea;
    wb_fwd_en = wb_reg_en & rst;
  end

  // Entries not addressed, or any entry while wb_reg_en=0, hold their value so
  // unknown data on DM/ALU_ea cannot reach storage.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (wb_fwd_en && (ra == AW'(i))) begin
        regs_d[i] = wb_data;
      end
    end
    wr_cnt_d = wb_fwd_en ? (wr_cnt_q + CNT_W'(1)) : wr_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wr_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr_cnt_q <= wr_cnt_d;
    end
  end

  generate
    if (BYPASS) begin : g_bypass
      always_comb begin
        rd_a = (wb_fwd_en && (rs_a == ra)) ? wb_data : regs_q[rs_a];
        rd_b = (wb_fwd_en && (rs_b == ra)) ? wb_data : regs_q[rs_b];
      end
    end else begin : g_no_bypass
      always_comb begin
        rd_a = regs_q[rs_a];
        rd_b = regs_q[rs_b];
      end
    end
  endgenerate

  assign wr_cnt = wr_cnt_q;

endmodule
